// File: rtl/register_bank_sequencer_pkg.sv
// register_bank_sequencer_pkg: shared register-file widths and sequencer state encoding
package register_bank_sequencer_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int XLEN = 32;
  localparam int REG_COUNT = 16;
  typedef enum logic [2:0] {IDLE, READ_A, READ_B, WRITE, RESP} seqState_t;
endpackage

// File: rtl/register_bank_sequencer.sv
// register_bank_sequencer: serialises rs1/rs2 reads then an rd write onto a single-port registered RegisterBank (req_* in, resp_*/rs*_data out, bank_* to the bank)
module register_bank_sequencer
  import register_bank_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  wr_en,
  input  logic [XLEN-1:0]       wr_data,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [REG_ADDR_W-1:0] bank_regNum,
  output logic [XLEN-1:0]       bank_dataIn,
  output logic                  bank_writeEnable,
  input  logic [XLEN-1:0]       bank_dataOut
);
  seqState_t state, nextState;
  logic [REG_ADDR_W-1:0] rs1Q, rs2Q, rdQ;
  logic wrEnQ;
  logic [XLEN-1:0] wrDataQ;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rs1Q <= '0;
      rs2Q <= '0;
      rdQ <= '0;
      wrEnQ <= 1'b0;
      wrDataQ <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && req_valid) begin
        rs1Q <= rs1;
        rs2Q <= rs2;
        rdQ <= rd;
        wrEnQ <= wr_en;
        wrDataQ <= wr_data;
      end
      if (state == READ_B) rs1_data <= (rs1Q == '0) ? '0 : bank_dataOut;
      if (state == WRITE) rs2_data <= (rs2Q == '0) ? '0 : bank_dataOut;
    end
  end
  always_comb begin
    nextState = (state == IDLE)   ? (req_valid ? READ_A : IDLE) :
                (state == READ_A) ? READ_B :
                (state == READ_B) ? WRITE :
                (state == WRITE)  ? RESP : IDLE;
    req_ready = (state == IDLE);
    resp_valid = (state == RESP);
    bank_regNum = (state == READ_A) ? rs1Q :
                  (state == READ_B) ? rs2Q :
                  (state == WRITE)  ? rdQ : '0;
    bank_dataIn = (state == WRITE) ? wrDataQ : '0;
    bank_writeEnable = (state == WRITE) && wrEnQ && (rdQ != '0);
  end
endmodule

// File: tb/tb_register_bank_sequencer.sv
// tb_register_bank_sequencer: directed checks of the sequencer against a behavioural registered RegisterBank
module tb_register_bank_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] rs1 = '0, rs2 = '0, rd = '0;
  logic wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic resp_valid;
  logic [31:0] rs1_data, rs2_data;
  logic [3:0] bank_regNum;
  logic [31:0] bank_dataIn;
  logic bank_writeEnable;
  logic [31:0] bank_dataOut;
  logic [31:0] bankMem [16] = '{default: 32'h0};
  logic pokeEn = 1'b0;
  logic [3:0] pokeAddr = '0;
  logic [31:0] pokeData = '0;
  int weCount = 0;
  int tests = 0;
  int failed = 0;
  int lat, wc0, accepts, resps, readyHigh, acc1, acc2, rsp1, rsp2;
  always #5 clk = ~clk;
  register_bank_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wr_en(wr_en), .wr_data(wr_data),
    .resp_valid(resp_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .bank_regNum(bank_regNum), .bank_dataIn(bank_dataIn),
    .bank_writeEnable(bank_writeEnable), .bank_dataOut(bank_dataOut)
  );
  always @(posedge clk or posedge reset) begin
    if (reset) bank_dataOut <= '0;
    else begin
      if (pokeEn) bankMem[pokeAddr] <= pokeData;
      else if (bank_writeEnable) bankMem[bank_regNum] <= bank_dataIn;
      bank_dataOut <= bankMem[bank_regNum];
    end
  end
  always @(posedge clk) if (!reset && bank_writeEnable) weCount <= weCount + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    pokeEn = 1'b1;
    pokeAddr = a;
    pokeData = d;
    tick();
    pokeEn = 1'b0;
  endtask
  task automatic doReq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                       input logic w, input logic [31:0] data, input bit churn, output int l);
    rs1 = a;
    rs2 = b;
    rd = d;
    wr_en = w;
    wr_data = data;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (l = 1; l <= 8 && !resp_valid; l++) begin
      if (churn) begin
        rs1 = rs1 + 4'd1;
        rs2 = rs2 + 4'd3;
        rd = rd + 4'd5;
        wr_en = ~wr_en;
        wr_data = $urandom;
      end
      tick();
    end
  endtask
  initial begin
    tick();
    tick();
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rs1_data", rs1_data, 32'd0);
    check("rst_rs2_data", rs2_data, 32'd0);
    check("rst_we", {31'b0, bank_writeEnable}, 32'd0);
    check("rst_regnum", {28'b0, bank_regNum}, 32'd0);
    reset = 1'b0;
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);
    poke(4'd5, 32'h12345678);
    poke(4'd9, 32'hCAFEBABE);
    wc0 = weCount;
    doReq(4'd5, 4'd9, 4'd2, 1'b0, 32'h55555555, 1'b0, lat);
    check("read_latency", lat, 32'd4);
    check("read_rs1", rs1_data, 32'h12345678);
    check("read_rs2", rs2_data, 32'hCAFEBABE);
    check("read_no_write", weCount - wc0, 32'd0);
    tick();
    wc0 = weCount;
    doReq(4'd3, 4'd3, 4'd3, 1'b1, 32'hFFFFFFFF, 1'b0, lat);
    check("rbw_rs1_old", rs1_data, 32'h0);
    check("rbw_rs2_old", rs2_data, 32'h0);
    check("rbw_one_write", weCount - wc0, 32'd1);
    check("rbw_mem3", bankMem[3], 32'hFFFFFFFF);
    tick();
    doReq(4'd3, 4'd5, 4'd0, 1'b0, 32'h0, 1'b0, lat);
    check("readback_rs1", rs1_data, 32'hFFFFFFFF);
    check("readback_rs2", rs2_data, 32'h12345678);
    tick();
    poke(4'd0, 32'hDEADBEEF);
    wc0 = weCount;
    doReq(4'd0, 4'd9, 4'd0, 1'b1, 32'h11111111, 1'b0, lat);
    check("r0_rs1_zero", rs1_data, 32'h0);
    check("r0_rs2", rs2_data, 32'hCAFEBABE);
    check("r0_no_we", weCount - wc0, 32'd0);
    check("r0_mem_kept", bankMem[0], 32'hDEADBEEF);
    tick();
    doReq(4'd9, 4'd0, 4'd1, 1'b0, 32'h0, 1'b0, lat);
    check("r0_rs1", rs1_data, 32'hCAFEBABE);
    check("r0_rs2_zero", rs2_data, 32'h0);
    tick();
    // Handshake window opens in the WRITE cycle of a preceding request
    rs1 = 4'd5;
    rs2 = 4'd9;
    rd = 4'd1;
    wr_en = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    req_valid = 1'b1;
    accepts = 0;
    resps = 0;
    readyHigh = 0;
    acc1 = -1;
    acc2 = -1;
    rsp1 = -1;
    rsp2 = -1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) begin
        readyHigh++;
        accepts++;
        if (accepts == 1) acc1 = i; else acc2 = i;
      end
      if (resp_valid && accepts > 0) begin
        resps++;
        if (resps == 1) rsp1 = i; else rsp2 = i;
      end
      if (i == 11) req_valid = 1'b0;
      tick();
    end
    check("hs_accepts", accepts, 32'd2);
    check("hs_resps", resps, 32'd2);
    check("hs_ready_cycles", readyHigh, 32'd2);
    check("hs_accept_gap", acc2 - acc1, 32'd5);
    check("hs_resp_gap", rsp2 - rsp1, 32'd5);
    check("hs_latency", rsp1 - acc1, 32'd4);
    check("hs_rs2_data", rs2_data, 32'hCAFEBABE);
    wc0 = weCount;
    rs1 = 4'd5;
    rs2 = 4'd9;
    rd = 4'd7;
    wr_en = 1'b1;
    wr_data = 32'hA5A5A5A5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_state_rb", {28'b0, bank_regNum}, 32'd9);
    #2 reset = 1'b1;
    #1;
    check("arst_resp", {31'b0, resp_valid}, 32'd0);
    check("arst_we", {31'b0, bank_writeEnable}, 32'd0);
    check("arst_rs2_data", rs2_data, 32'h0);
    check("arst_regnum", {28'b0, bank_regNum}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    check("ready_after_rel", {31'b0, req_ready}, 32'd1);
    resps = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) resps++;
      tick();
    end
    check("abandon_no_resp", resps, 32'd0);
    check("abandon_mem7", bankMem[7], 32'h0);
    check("abandon_no_write", weCount - wc0, 32'd0);
    wc0 = weCount;
    doReq(4'd5, 4'd9, 4'd4, 1'b1, 32'h0BADF00D, 1'b1, lat);
    check("churn_latency", lat, 32'd4);
    check("churn_rs1", rs1_data, 32'h12345678);
    check("churn_rs2", rs2_data, 32'hCAFEBABE);
    check("churn_one_write", weCount - wc0, 32'd1);
    check("churn_mem4", bankMem[4], 32'h0BADF00D);
    tick();
    check("idle_regnum", {28'b0, bank_regNum}, 32'd0);
    check("idle_datain", bank_dataIn, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
